// File: rtl/vx_gpu_pkg.sv
// Shared GPU package: operand bundle layout handed from the per-slice operand
// collectors to a shared functional unit, the skid buffer state encoding and
// a select-width helper.
package vx_gpu_pkg;

  // One issued instruction's operands: four threads of 32-bit register data.
  typedef struct packed {
    logic [43:0]  uuid;
    logic [1:0]   wis;
    logic [3:0]   tmask;
    logic [31:0]  pc;
    logic [2:0]   ex_type;
    logic [3:0]   op_type;
    logic         use_imm;
    logic         wb;
    logic [31:0]  imm;
    logic [4:0]   rd;
    logic [127:0] rs1_data;
    logic [127:0] rs2_data;
    logic [127:0] rs3_data;
  } operands_t;

  localparam int OPERANDS_W = $bits(operands_t);

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_operands_arb_chk.sv
// Checker for the arbiter's interface contract: a request that was not
// accepted must stay valid with unchanged data on the next cycle, and at most
// one slice is granted per cycle.
// Ports: clk, reset_n, and the arbiter's in_valid/in_data/in_ready (observe only).
module vx_operands_arb_chk
  import vx_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATA_W   = OPERANDS_W
) (
  input logic                       clk,
  input logic                       reset_n,
  input logic [NUM_REQS-1:0]        in_valid,
  input logic [NUM_REQS*DATA_W-1:0] in_data,
  input logic [NUM_REQS-1:0]        in_ready
);

  logic [NUM_REQS-1:0]        wait_r;
  logic [NUM_REQS*DATA_W-1:0] data_r;

  // Remember which requests were left waiting and what they carried.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_r <= {NUM_REQS{1'b0}};
      data_r <= {(NUM_REQS*DATA_W){1'b0}};
    end else begin
      wait_r <= in_valid & ~in_ready;
      data_r <= in_data;
    end
  end

  // Contract checks, reading the previous-cycle record before it updates.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert ($onehot0(in_ready));
      for (int i = 0; i < NUM_REQS; i++) begin
        assert (!wait_r[i] || (in_valid[i] &&
                (in_data[i*DATA_W +: DATA_W] == data_r[i*DATA_W +: DATA_W])));
      end
    end
  end

endmodule

// File: rtl/vx_rr_skid_buf.sv
// Two-entry registered valid/ready buffer (main + skid). Every output is a
// flop, so there is no combinational path from out_ready to in_ready.
// Ports: clk, reset_n (async, active-low); in_valid/in_data/in_ready upstream
// handshake (in_ready = not full); out_valid/out_data/out_ready downstream.
module vx_rr_skid_buf
  import vx_gpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  buf_state_e       state_r, state_s;
  logic [WIDTH-1:0] main_r, main_s;
  logic [WIDTH-1:0] skid_r, skid_s;
  logic             full_r;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = ~full_r;
  assign out_valid = valid_r;
  assign out_data  = main_r;
  assign push_s    = in_valid & ~full_r;
  assign pop_s     = valid_r & out_ready;

  // Next occupancy and entry contents; main is always the head of the queue.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    case (state_r)
      BUF_EMPTY: begin
        if (push_s) begin
          state_s = BUF_ONE;
          main_s  = in_data;
        end else begin
          state_s = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (push_s && pop_s) begin
          main_s = in_data;
        end else if (push_s) begin
          state_s = BUF_FULL;
          skid_s  = in_data;
        end else if (pop_s) begin
          state_s = BUF_EMPTY;
        end else begin
          state_s = BUF_ONE;
        end
      end
      BUF_FULL: begin
        if (pop_s) begin
          state_s = BUF_ONE;
          main_s  = skid_r;
        end else begin
          state_s = BUF_FULL;
        end
      end
      default: begin
        state_s = BUF_EMPTY;
      end
    endcase
  end

  // State and data registers; full/valid flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BUF_EMPTY;
      main_r  <= {WIDTH{1'b0}};
      skid_r  <= {WIDTH{1'b0}};
      full_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
      full_r  <= (state_s == BUF_FULL);
      valid_r <= (state_s != BUF_EMPTY);
    end
  end

endmodule

// File: rtl/vx_operands_arb.sv
// Round-robin arbiter sharing one execute-unit operand port among NUM_REQS
// issue slices, with a fully registered two-entry output buffer.
// Ports: clk, reset_n (async, active-low); in_valid/in_data/in_ready per-slice
// request handshake (slice i at in_data[i*DATA_W +: DATA_W]); out_valid/
// out_data/out_sel/out_ready towards the shared unit; perf_stalls counts
// cycles with out_valid high and out_ready low (saturating).
module vx_operands_arb
  import vx_gpu_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATA_W     = OPERANDS_W,
  parameter int PERF_CTR_W = 32,
  localparam int SEL_W     = log2up(NUM_REQS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQS-1:0]        in_valid,
  input  logic [NUM_REQS*DATA_W-1:0] in_data,
  output logic [NUM_REQS-1:0]        in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_sel,
  input  logic                       out_ready,
  output logic [PERF_CTR_W-1:0]      perf_stalls
);

  logic [NUM_REQS-1:0]     grant_s;
  logic [SEL_W-1:0]        grant_idx_s;
  logic                    grant_any_s;
  logic                    buf_ready_s;
  logic                    can_accept_s;
  logic [DATA_W-1:0]       grant_data_s;
  logic [SEL_W+DATA_W-1:0] buf_out_s;
  logic [PERF_CTR_W-1:0]   perf_stalls_r;

  // Gating with reset_n keeps every in_ready low while reset is held.
  assign can_accept_s = reset_n & buf_ready_s;
  assign in_ready     = grant_s & {NUM_REQS{can_accept_s}};
  assign grant_data_s = in_data[int'(grant_idx_s)*DATA_W +: DATA_W];

  if (NUM_REQS == 1) begin : g_single
    assign grant_s     = in_valid;
    assign grant_idx_s = {SEL_W{1'b0}};
    assign grant_any_s = in_valid[0];
  end else begin : g_rr
    logic [SEL_W-1:0] rr_ptr_r;
    logic             push_s;

    assign push_s = grant_any_s & can_accept_s;

    // First valid slice at or after rr_ptr, wrapping past the top index.
    always_comb begin
      int   idx_v;
      logic hit_v;
      grant_s     = {NUM_REQS{1'b0}};
      grant_idx_s = {SEL_W{1'b0}};
      grant_any_s = 1'b0;
      idx_v       = 0;
      hit_v       = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
        idx_v          = int'(rr_ptr_r) + k;
        idx_v          = (idx_v >= NUM_REQS) ? (idx_v - NUM_REQS) : idx_v;
        hit_v          = in_valid[idx_v] & ~grant_any_s;
        grant_s[idx_v] = hit_v;
        grant_idx_s    = hit_v ? SEL_W'(idx_v) : grant_idx_s;
        grant_any_s    = grant_any_s | hit_v;
      end
    end

    // Priority moves just past the slice that transferred; otherwise it holds.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rr_ptr_r <= {SEL_W{1'b0}};
      end else if (push_s) begin
        rr_ptr_r <= (grant_idx_s == SEL_W'(NUM_REQS-1)) ? {SEL_W{1'b0}}
                                                        : grant_idx_s + SEL_W'(1);
      end
    end
  end

  // The slice index travels alongside its bundle through the buffer.
  vx_rr_skid_buf #(
    .WIDTH (SEL_W + DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (grant_any_s),
    .in_data   ({grant_idx_s, grant_data_s}),
    .in_ready  (buf_ready_s),
    .out_valid (out_valid),
    .out_data  (buf_out_s),
    .out_ready (out_ready)
  );

  assign out_sel     = buf_out_s[SEL_W+DATA_W-1:DATA_W];
  assign out_data    = buf_out_s[DATA_W-1:0];
  assign perf_stalls = perf_stalls_r;

  // Backpressure counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stalls_r <= {PERF_CTR_W{1'b0}};
    end else if (out_valid && !out_ready && (perf_stalls_r != {PERF_CTR_W{1'b1}})) begin
      perf_stalls_r <= perf_stalls_r + PERF_CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_vx_operands_arb.sv
// Testbench for vx_operands_arb: table-driven directed vectors, a hand-written
// asynchronous-reset sequence, and randomized traffic against a queue model.
module tb_vx_operands_arb;
  import vx_gpu_pkg::*;

  localparam int N  = 4;
  localparam int W  = OPERANDS_W;
  localparam int SW = log2up(N);
  localparam int PW = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready = 1'b0;
  logic [PW-1:0]  perf_stalls;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]  v;
    logic          r;
    logic [N-1:0]  ir;
    logic          ov;
    logic [SW-1:0] sel;
    logic [PW-1:0] st;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  vx_operands_arb #(.NUM_REQS(N), .DATA_W(W), .PERF_CTR_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .perf_stalls(perf_stalls)
  );

  vx_operands_arb_chk #(.NUM_REQS(N), .DATA_W(W)) chk (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Fixed per-slice bundle: every byte 0xA3+slice (slice 2 is 0xA5...).
  function automatic logic [W-1:0] pat(input int s);
    logic [7:0] b;
    b = 8'hA3 + 8'(s);
    return {(W/8){b}};
  endfunction

  function automatic logic [W-1:0] rand_bundle();
    logic [W-1:0] r;
    for (int j = 0; j < W/32; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic void add(input logic [N-1:0] v, input logic r, input logic [N-1:0] ir,
                              input logic ov, input logic [SW-1:0] sel, input int st);
    vec_t t;
    t.v = v; t.r = r; t.ir = ir; t.ov = ov; t.sel = sel; t.st = PW'(st);
    tbl.push_back(t);
  endfunction

  // Holds reset with all slices requesting, checks reset values, then releases.
  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = '1;
    out_ready = 1'b0;
    #2;
    check("rst in_ready", in_ready, '0);
    check("rst out_valid", out_valid, '0);
    check("rst out_data", out_data, '0);
    check("rst out_sel", out_sel, '0);
    check("rst perf_stalls", perf_stalls, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    in_valid = '0;
  endtask

  // Randomized traffic against a capacity-2 FIFO model with rotating priority.
  task automatic run_random(input int ncyc);
    int           q_sel[$];
    logic [W-1:0] q_dat[$];
    int           ptr;
    int           stalls;
    int           g;
    int           idx;
    bit           stall;
    logic [N-1:0] pend;
    logic [N-1:0] exp_ir;
    logic [N-1:0] one;
    ptr = 0; stalls = 0; pend = '0; one = 1;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          in_valid[i] = ($urandom_range(0, 99) < 45);
          if (in_valid[i]) in_data[i*W +: W] = rand_bundle();
        end
      end
      out_ready = ($urandom_range(0, 99) < 60);
      pend = in_valid;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (g < 0 && in_valid[idx]) g = idx;
      end
      exp_ir = (g >= 0 && q_sel.size() < 2) ? (one << g) : '0;
      check($sformatf("rnd%0d in_ready", c), in_ready, exp_ir);
      check($sformatf("rnd%0d out_valid", c), out_valid, (q_sel.size() > 0));
      if (q_sel.size() > 0) begin
        check($sformatf("rnd%0d out_sel", c), out_sel, q_sel[0]);
        check($sformatf("rnd%0d out_data", c), out_data, q_dat[0]);
      end
      check($sformatf("rnd%0d perf_stalls", c), perf_stalls, stalls);
      stall = (q_sel.size() > 0) && !out_ready;
      if (stall) stalls++;
      if (q_sel.size() > 0 && out_ready) begin
        void'(q_sel.pop_front());
        void'(q_dat.pop_front());
      end
      if (exp_ir != '0) begin
        q_sel.push_back(g);
        q_dat.push_back(in_data[g*W +: W]);
        ptr = (g + 1) % N;
        pend[g] = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = pat(i);
    #1;
    do_reset();

    // Single request to slice 2, then slices 3/0 wrap-around from rr_ptr=1.
    add(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 0);
    add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 0);
    add(4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 0);
    add(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 0);
    add(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 0);
    add(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 0);
    add(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 0);
    add(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd0, 0);
    add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 0);
    // All slices valid: five cycles of backpressure, then full-rate rotation.
    add(4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 0);
    add(4'b1111, 1'b0, 4'b0010, 1'b1, 2'd0, 0);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 2);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 3);
    add(4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 4);
    add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 4);
    add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 4);
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 4);
    add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      out_ready = tbl[i].r;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i), in_ready, tbl[i].ir);
      check($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        check($sformatf("row%0d out_sel", i), out_sel, tbl[i].sel);
        check($sformatf("row%0d out_data", i), out_data, pat(int'(tbl[i].sel)));
      end
      check($sformatf("row%0d perf_stalls", i), perf_stalls, tbl[i].st);
      @(posedge clk); #1;
    end

    // Asynchronous reset while the buffer is full.
    do_reset();
    in_valid = '1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("full out_valid", out_valid, 1'b1);
    check("full in_ready", in_ready, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 1'b0);
    check("async out_data", out_data, '0);
    check("async perf_stalls", perf_stalls, '0);
    check("async in_ready", in_ready, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-rst out_valid", out_valid, 1'b1);
    check("post-rst out_sel", out_sel, 2'd0);
    check("post-rst out_data", out_data, pat(0));
    check("post-rst perf_stalls", perf_stalls, '0);

    do_reset();
    run_random(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
